// File: rtl/bitfusion_psum_accumulator.sv
// bitfusion_psum_accumulator: sums a programmed count of multiplier products into one wide result.
// Results leave over a valid/ready handshake, and the overflow flag is sticky for each result.
module bitfusion_psum_accumulator #(
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  signed_mode,
    input  logic                  psum_valid,
    input  logic [PSUM_WIDTH-1:0] psum,
    output logic                  psum_ready,
    output logic                  acc_valid,
    output logic [ACC_WIDTH-1:0]  acc_out,
    input  logic                  acc_ready,
    output logic                  busy,
    output logic                  overflow
);
    localparam int EXT = ACC_WIDTH - PSUM_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_d;
    logic                 signed_q, ovf_q, ovf_d, last_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, ext_d;

    assign ext_d  = {{EXT{signed_q & psum[PSUM_WIDTH-1]}}, psum};
    assign acc_d  = acc_q + ext_d;
    assign cnt_d  = cnt_q + 1'b1;
    assign last_d = cnt_d == len_q;
    // Overflow always uses the signed view of the operands and the sum, whatever the mode.
    assign ovf_d  = (acc_q[ACC_WIDTH-1] == ext_d[ACC_WIDTH-1]) && (acc_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_q    <= len;
                    signed_q <= signed_mode;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    ovf_q    <= 1'b0;
                    state_q  <= (len == '0) ? OUT : ACCUM;
                end
                ACCUM: if (psum_valid) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_q | ovf_d;
                    if (last_d) state_q <= OUT;
                end
                OUT: if (acc_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psum_ready = state_q == ACCUM;
    assign acc_valid  = state_q == OUT;
    assign busy       = state_q != IDLE;
    assign acc_out    = acc_q;
    assign overflow   = ovf_q;
endmodule
